// File: rtl/q44_mul_arbiter.sv
// Round-robin arbiter sharing one external Q4.4 multiplier among N requesters, with drain/halt quiesce FSM.
// Optional build macro Q44_MUL_ARB_STATS_EN adds a saturated-result counter output (sat_cnt).
module q44_mul_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             drain,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     rsp_valid,
  output logic [W-1:0]     rsp_data,
  output logic [W-1:0]     mul_x1,
  output logic [W-1:0]     mul_x2,
  input  logic [W-1:0]     mul_p,
  output logic             halted,
  output logic             busy
`ifdef Q44_MUL_ARB_STATS_EN
  ,
  output logic [15:0]      sat_cnt
`endif
);

  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = MUL_LAT + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [DEPTH-1:0]          tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][PW-1:0]  tag_idx_q, tag_idx_d;
  logic [W-1:0]              mul_x1_q, mul_x1_d;
  logic [W-1:0]              mul_x2_q, mul_x2_d;
  logic [N-1:0]              rsp_valid_q, rsp_valid_d;
  logic [W-1:0]              rsp_data_q, rsp_data_d;

  logic                      grant_en;
  logic                      gnt_hit;
  logic [PW-1:0]             gnt_idx;
  logic [PW-1:0]             cand;
  logic                      in_flight;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return s[PW-1:0];
  endfunction

  // drain masks grants in the same cycle it rises, before the FSM has left RUN
  always_comb begin
    grant_en  = (state_q == ST_RUN) && !drain;
    gnt_hit   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    for (int k = 0; k < N; k++) begin
      cand = wrap_add(ptr_q, k);
      if (grant_en && !gnt_hit && req_valid[cand]) begin
        gnt_hit = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_hit) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d    = ptr_q;
    mul_x1_d = mul_x1_q;
    mul_x2_d = mul_x2_q;
    if (gnt_hit) begin
      ptr_d    = wrap_add(gnt_idx, 1);
      mul_x1_d = req_a[int'(gnt_idx)*W +: W];
      mul_x2_d = req_b[int'(gnt_idx)*W +: W];
    end
  end

  // Tag pipeline: last stage lines up with the product on mul_p
  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = '0;
    tag_vld_d[0] = gnt_hit;
    tag_idx_d[0] = gnt_hit ? gnt_idx : '0;
    for (int s = 1; s < DEPTH; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_vld_q[DEPTH-1]) begin
      rsp_valid_d[tag_idx_q[DEPTH-1]] = 1'b1;
      rsp_data_d                      = mul_p;
    end
  end

  assign in_flight = |tag_vld_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (drain) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain)          state_d = ST_RUN;
        else if (!in_flight) state_d = ST_HALT;
      end
      ST_HALT:  if (!drain) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      tag_idx_q   <= '0;
      mul_x1_q    <= '0;
      mul_x2_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_idx_q   <= tag_idx_d;
      mul_x1_q    <= mul_x1_d;
      mul_x2_q    <= mul_x2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mul_x1    = mul_x1_q;
  assign mul_x2    = mul_x2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign halted    = (state_q == ST_HALT);
  assign busy      = in_flight | (|rsp_valid_q);

`ifdef Q44_MUL_ARB_STATS_EN
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Counts delivered responses sitting on either saturation rail
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if ((|rsp_valid_q) && ((rsp_data_q == SAT_POS) || (rsp_data_q == SAT_NEG)) &&
        (sat_cnt_q != 16'hFFFF))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_q44_mul_arbiter.sv
// Directed bench for q44_mul_arbiter with a 1-cycle Q4.4 saturating multiplier model.
module tb_q44_mul_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           drain;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [W-1:0]   mul_x1;
  logic [W-1:0]   mul_x2;
  logic [W-1:0]   mul_p;
  logic           halted;
  logic           busy;
`ifdef Q44_MUL_ARB_STATS_EN
  logic [15:0]    sat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  q44_mul_arbiter #(.N(N), .W(W), .MUL_LAT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .drain     (drain),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mul_x1    (mul_x1),
    .mul_x2    (mul_x2),
    .mul_p     (mul_p),
    .halted    (halted),
    .busy      (busy)
`ifdef Q44_MUL_ARB_STATS_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] qmul(input logic [7:0] x, input logic [7:0] y);
    logic signed [7:0] sx;
    logic signed [7:0] sy;
    int p;
    int r;
    sx = x;
    sy = y;
    p  = int'(sx) * int'(sy);
    r  = (p + 8) >>> 4;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  // External multiplier stand-in, one cycle of latency
  initial mul_p = '0;
  always @(posedge clk) mul_p <= qmul(mul_x1, mul_x2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  typedef struct {
    int         r;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    int max_gap;
    logic [N-1:0] exp_rdy;
    logic [7:0]   exp_d;

    tbl[0] = '{0, 8'h10, 8'h10, 8'h10};
    tbl[1] = '{1, 8'h70, 8'h70, 8'h7F};
    tbl[2] = '{2, 8'h80, 8'h70, 8'h80};
    tbl[3] = '{1, 8'hF0, 8'h20, 8'hE0};
    tbl[4] = '{0, 8'h08, 8'h08, 8'h04};
    tbl[5] = '{3, 8'h20, 8'h18, 8'h30};

    rst = 1'b1; drain = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    #1;
    chk("rst_rdy",    32'(req_ready), 32'h0);
    chk("rst_rspv",   32'(rsp_valid), 32'h0);
    chk("rst_rspd",   32'(rsp_data),  32'h0);
    chk("rst_x1",     32'(mul_x1),    32'h0);
    chk("rst_x2",     32'(mul_x2),    32'h0);
    chk("rst_halted", 32'(halted),    32'h0);
    chk("rst_busy",   32'(busy),      32'h0);
    cyc(); cyc();
    rst = 1'b0;

    // Single requests, exact 3-cycle latency
    for (int v = 0; v < 6; v++) begin
      cyc();
      req_valid = '0; req_a = '0; req_b = '0;
      req_valid[tbl[v].r]        = 1'b1;
      req_a[tbl[v].r*W +: W]     = tbl[v].a;
      req_b[tbl[v].r*W +: W]     = tbl[v].b;
      #1 chk("vec_rdy", 32'(req_ready), 32'(1 << tbl[v].r));
      cyc(); req_valid = '0;
      #1 chk("vec_c1_rspv", 32'(rsp_valid), 32'h0);
      chk("vec_c1_x1", 32'(mul_x1), 32'(tbl[v].a));
      chk("vec_c1_busy", 32'(busy), 32'h1);
      cyc();
      #1 chk("vec_c2_rspv", 32'(rsp_valid), 32'h0);
      cyc();
      #1 chk("vec_c3_rspv", 32'(rsp_valid), 32'(1 << tbl[v].r));
      chk("vec_c3_rspd", 32'(rsp_data), 32'(tbl[v].e));
      cyc();
      #1 chk("vec_c4_rspv", 32'(rsp_valid), 32'h0);
      chk("vec_c4_hold", 32'(rsp_data), 32'(tbl[v].e));
      chk("vec_c4_busy", 32'(busy), 32'h0);
    end
`ifdef Q44_MUL_ARB_STATS_EN
    chk("sat_cnt", 32'(sat_cnt), 32'd2);
`endif

    // All requesters valid from ptr=0: grants 0,1,2,3,... and in-order responses
    req_a = {4{8'h10}};
    req_b = {8'h50, 8'h40, 8'h30, 8'h20};
    for (int c = 0; c < 12; c++) begin
      cyc();
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      exp_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      chk("rr_rdy", 32'(req_ready), 32'(exp_rdy));
      if (c >= 3 && c < 11) begin
        chk("rr_rspv", 32'(rsp_valid), 32'(1 << ((c - 3) % 4)));
        exp_d = 8'(32'h20 + 32'h10 * ((c - 3) % 4));
        chk("rr_rspd", 32'(rsp_data), 32'(exp_d));
      end else begin
        chk("rr_rspv_idle", 32'(rsp_valid), 32'h0);
      end
    end

    // Fairness: req 2 steady, req 0 toggling
    gap = 0; max_gap = 0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      req_valid = (c % 2 == 0) ? 4'b0101 : 4'b0100;
      #1;
      chk("fair_rdy", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h4);
      if (req_ready[2]) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
    end
    chk("fair_gap", 32'(max_gap <= N - 1), 32'h1);
    cyc(); req_valid = '0;
    repeat (4) cyc();

    // Drain with two operations in flight (ptr=3 here)
    req_valid = 4'b0010;
    #1 chk("dr_rdy_a", 32'(req_ready), 32'h2);
    cyc(); req_valid = 4'b1000;
    #1 chk("dr_rdy_b", 32'(req_ready), 32'h8);
    cyc(); req_valid = 4'hF; drain = 1'b1;
    #1 chk("dr_mask", 32'(req_ready), 32'h0);
    chk("dr_c_busy", 32'(busy), 32'h1);
    cyc();
    #1 chk("dr_d_rdy", 32'(req_ready), 32'h0);
    chk("dr_d_rspv", 32'(rsp_valid), 32'h2);
    chk("dr_d_rspd", 32'(rsp_data), 32'h30);
    chk("dr_d_halt", 32'(halted), 32'h0);
    cyc();
    #1 chk("dr_e_rspv", 32'(rsp_valid), 32'h8);
    chk("dr_e_rspd", 32'(rsp_data), 32'h50);
    chk("dr_e_halt", 32'(halted), 32'h0);
    chk("dr_e_busy", 32'(busy), 32'h1);
    cyc();
    #1 chk("dr_f_halt", 32'(halted), 32'h1);
    chk("dr_f_busy", 32'(busy), 32'h0);
    chk("dr_f_rdy", 32'(req_ready), 32'h0);
    cyc(); drain = 1'b0;
    #1 chk("dr_g_rdy", 32'(req_ready), 32'h0);
    chk("dr_g_halt", 32'(halted), 32'h1);
    cyc();
    #1 chk("dr_h_halt", 32'(halted), 32'h0);
    chk("dr_h_rdy", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    repeat (5) cyc();
    chk("pre_rst_rspd", 32'(rsp_data), 32'h20);

    // Reset one cycle after a grant (ptr=1 here)
    req_valid = 4'b0100;
    #1 chk("mr_rdy", 32'(req_ready), 32'h4);
    cyc(); req_valid = '0;
    #1 chk("mr_x1_pre", 32'(mul_x1), 32'h10);
    rst = 1'b1;
    #1 chk("mr_x1", 32'(mul_x1), 32'h0);
    chk("mr_x2", 32'(mul_x2), 32'h0);
    chk("mr_rspd", 32'(rsp_data), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_halt", 32'(halted), 32'h0);
    cyc(); rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      #1 chk("mr_no_rsp", 32'(rsp_valid), 32'h0);
    end
    req_valid = 4'hF;
    #1 chk("mr_ptr0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
